// File: rtl/gate_accum.sv
// Multi-operand bitwise gate: folds a stream of words with OR/AND/XOR (optionally
// inverted at the output) and presents the result, its reduction and a beat count.
module gate_accum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_bit,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [1:0] OP_OR  = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Reserved encodings 110/111 fall into the OR default.
    function automatic logic [1:0] base_op(input logic [2:0] m);
        case (m)
            3'b001, 3'b100: base_op = OP_AND;
            3'b010, 3'b101: base_op = OP_XOR;
            default:        base_op = OP_OR;
        endcase
    endfunction

    function automatic logic is_inv(input logic [2:0] m);
        is_inv = (m == 3'b011) || (m == 3'b100) || (m == 3'b101);
    endfunction

    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            OP_AND:  apply_op = a & b;
            OP_XOR:  apply_op = a ^ b;
            default: apply_op = a | b;
        endcase
    endfunction

    function automatic logic reduce_op(input logic [1:0] op, input logic [WIDTH-1:0] v);
        case (op)
            OP_AND:  reduce_op = &v;
            OP_XOR:  reduce_op = ^v;
            default: reduce_op = |v;
        endcase
    endfunction

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [2:0]       r_mode;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_word;
    logic             r_out_bit;
    logic [CNT_W-1:0] r_out_count;

    logic             w_first;
    logic             w_accept;
    logic [2:0]       w_mode_eff;
    logic [1:0]       w_op;
    logic             w_inv;
    logic [WIDTH-1:0] w_acc_next;
    logic [CNT_W-1:0] w_count_next;
    logic [WIDTH-1:0] w_result_word;
    logic             w_result_bit;

    assign in_ready = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign w_first  = (r_state == S_IDLE);
    assign w_accept = in_valid && in_ready;

    // The first beat takes the live mode; later beats use the captured one.
    assign w_mode_eff   = w_first ? mode : r_mode;
    assign w_op         = base_op(w_mode_eff);
    assign w_inv        = is_inv(w_mode_eff);
    assign w_acc_next   = w_first ? in_data : apply_op(w_op, r_acc, in_data);
    assign w_count_next = w_first ? CNT_ONE
                        : ((r_count == CNT_MAX) ? r_count : r_count + CNT_ONE);

    // Inversion applies only to what leaves the block, never to the accumulator.
    assign w_result_word = w_inv ? ~w_acc_next : w_acc_next;
    assign w_result_bit  = reduce_op(w_op, w_acc_next) ^ w_inv;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_mode      <= 3'b000;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_bit   <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_next;
                        r_count <= w_count_next;
                        if (w_first) begin
                            r_mode <= mode;
                        end
                        if (in_last) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                            r_out_word  <= w_result_word;
                            r_out_bit   <= w_result_bit;
                            r_out_count <= w_count_next;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_bit   = r_out_bit;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_gate_accum.sv
// Directed scoreboard bench for gate_accum; a second instance with CNT_W=2
// shares the stimulus to exercise count saturation.
module tb_gate_accum;

    typedef struct {
        logic [7:0] w;
        logic       b;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic [2:0] mode;
    logic       out_ready;

    logic       in_ready, in_ready2;
    logic       out_valid, out_valid2;
    logic [7:0] out_word, out_word2;
    logic       out_bit, out_bit2;
    logic [7:0] out_count;
    logic [1:0] out_count2;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    gate_accum #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_bit(out_bit), .out_count(out_count)
    );

    gate_accum #(.WIDTH(8), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .in_last(in_last), .mode(mode),
        .out_valid(out_valid2), .out_ready(out_ready), .out_word(out_word2),
        .out_bit(out_bit2), .out_count(out_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] w, input logic b, input int n);
        exp_t e;
        e.w  = w;
        e.b  = b;
        e.c8 = 8'(n);
        e.c2 = (n > 3) ? 2'd3 : 2'(n);
        sb.push_back(e);
    endtask

    // Entered and left at a falling edge; the beat is taken on the rising edge between.
    task automatic beat(input logic [7:0] d, input logic last, input logic [2:0] m);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode     = m;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_for_beat", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("out_latency", n, 0);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL sb_empty: observed output with no expected entry");
        end else begin
            e = sb.pop_front();
            check("out_valid",  out_valid,  1);
            check("out_word",   out_word,   e.w);
            check("out_bit",    out_bit,    e.b);
            check("out_count",  out_count,  e.c8);
            check("sat_valid",  out_valid2, 1);
            check("sat_word",   out_word2,  e.w);
            check("sat_bit",    out_bit2,   e.b);
            check("sat_count",  out_count2, e.c2);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        mode = 3'b000; out_ready = 1'b0;
        idle(2);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_word",  out_word,  0);
        check("rst_out_bit",   out_bit,   0);
        check("rst_out_count", out_count, 0);
        rst = 1'b0;
        idle(1);

        // OR, two beats
        beat(8'h01, 1'b0, 3'b000);
        beat(8'h80, 1'b1, 3'b000);
        push(8'h81, 1'b1, 2);
        wait_valid(); compare_front(); release_out();

        // AND with stalls; mode change mid-packet ignored
        beat(8'hFF, 1'b0, 3'b001);
        idle(2);
        check("stall_no_valid", out_valid, 0);
        beat(8'hF0, 1'b0, 3'b010);
        idle(2);
        beat(8'h3C, 1'b1, 3'b010);
        push(8'h30, 1'b0, 3);
        wait_valid(); compare_front(); release_out();

        // XNOR
        beat(8'hAA, 1'b0, 3'b101);
        beat(8'h0F, 1'b1, 3'b101);
        push(8'h5A, 1'b1, 2);
        wait_valid(); compare_front(); release_out();

        // single-beat NOR
        beat(8'h00, 1'b1, 3'b011);
        push(8'hFF, 1'b1, 1);
        wait_valid(); compare_front(); release_out();

        // reserved mode acts as OR
        beat(8'h05, 1'b0, 3'b110);
        beat(8'h50, 1'b1, 3'b110);
        push(8'h55, 1'b1, 2);
        wait_valid(); compare_front(); release_out();

        // backpressure in HOLD with a beat pending
        beat(8'h3C, 1'b0, 3'b010);
        beat(8'h0F, 1'b1, 3'b010);
        push(8'h33, 1'b0, 2);
        wait_valid();
        in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1; mode = 3'b000;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready",  in_ready,  0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_word",  out_word,  8'h33);
            check("bp_out_count", out_count, 2);
        end
        compare_front();
        push(8'h77, 1'b1, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_handoff_valid", out_valid, 0);
        check("bp_idle_ready",    in_ready,  1);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        wait_valid(); compare_front(); release_out();

        // saturation on the CNT_W=2 instance
        beat(8'h01, 1'b0, 3'b000);
        beat(8'h02, 1'b0, 3'b000);
        beat(8'h04, 1'b0, 3'b000);
        beat(8'h08, 1'b0, 3'b000);
        beat(8'h10, 1'b1, 3'b000);
        push(8'h1F, 1'b1, 5);
        wait_valid(); compare_front(); release_out();

        // asynchronous reset mid-ACCUM
        beat(8'h11, 1'b0, 3'b000);
        beat(8'h22, 1'b0, 3'b000);
        #2 rst = 1'b1;
        #1;
        check("arst_acc_valid", out_valid, 0);
        check("arst_acc_ready", in_ready,  1);
        check("arst_acc_word",  out_word,  0);
        check("arst_acc_count", out_count, 0);
        @(negedge clk);
        rst = 1'b0;
        beat(8'h0C, 1'b1, 3'b000);
        push(8'h0C, 1'b1, 1);
        wait_valid(); compare_front(); release_out();

        // asynchronous reset in HOLD discards the pending result
        beat(8'hF0, 1'b1, 3'b001);
        check("hold_before_rst", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_hold_valid", out_valid, 0);
        check("arst_hold_ready", in_ready,  1);
        check("arst_hold_word",  out_word,  0);
        @(negedge clk);
        rst = 1'b0;

        // in_last without in_valid does nothing
        in_last = 1'b1;
        idle(2);
        check("last_no_valid", out_valid, 0);
        in_last = 1'b0;

        // NAND
        beat(8'hF0, 1'b0, 3'b100);
        beat(8'h3C, 1'b1, 3'b100);
        push(8'hCF, 1'b1, 2);
        wait_valid(); compare_front(); release_out();

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
